// File: rtl/recebe_ascii_bcd.sv
// Serial ASCII digit receiver that pairs digits into packed BCD.
// Optional even-parity frame selected by defining RX_PARITY_EN.
module recebe_ascii_bcd #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] bcd,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA  = 4'd2,
    S_PAR   = 4'd3,
    S_STOP  = 4'd4,
    S_CHECK = 4'd5
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          stop_q;
  logic          alto_q;
  logic [3:0]    tens_q;
  logic [7:0]    bcd_q;
  logic          pronto_q;
  logic          erro_q;
  logic          char_ok;
`ifdef RX_PARITY_EN
  logic          par_q;
`endif

  // Two-flop synchronizer plus one delayed copy for fall detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A character is accepted only if framed correctly and in '0'..'9'.
  always_comb begin
    char_ok = stop_q && (data_q >= 8'h30) && (data_q <= 8'h39);
`ifdef RX_PARITY_EN
    if ((^data_q) ^ par_q)
      char_ok = 1'b0;
`endif
  end

  // Receive FSM, digit pairing and registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      stop_q   <= 1'b0;
      alto_q   <= 1'b1;
      tens_q   <= '0;
      bcd_q    <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            if (!sync2_q) begin
              bit_q   <= '0;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q  <= '0;
            data_q <= {sync2_q, data_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        S_PAR: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            par_q   <= sync2_q;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            stop_q  <= sync2_q;
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          if (!char_ok) begin
            erro_q <= 1'b1;
            alto_q <= 1'b1;
            tens_q <= '0;
          end else if (alto_q) begin
            tens_q <= data_q[3:0];
            alto_q <= 1'b0;
          end else begin
            bcd_q    <= {tens_q, data_q[3:0]};
            pronto_q <= 1'b1;
            alto_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_recebe_ascii_bcd.sv
// Testbench for recebe_ascii_bcd: table vectors, corner sequences,
// and random characters checked against a digit-pairing model.
module tb_recebe_ascii_bcd;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] bcd;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_bad = 0;
  int np = 0;
  int ne = 0;
  bit prev_strobe = 1'b0;

  int         held = -1;
  logic [7:0] mbcd = 8'h00;

  typedef struct {
    logic [7:0] ch;
    bit         stop;
    int         exp_p;
    int         exp_e;
    logic [7:0] exp_bcd;
  } vec_t;

  vec_t tbl[19];

  always #5 clock = ~clock;

  recebe_ascii_bcd #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_serial (rx_serial),
    .bcd       (bcd),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (pronto) np++;
    if (erro) ne++;
    if (pronto || erro) begin
      chk("strobe_exclusive", int'(pronto && erro), 0);
      chk("strobe_one_cycle", int'(prev_strobe), 0);
    end
    prev_strobe = pronto || erro;
  end

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit stop,
                            input bit pbad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
`ifdef RX_PARITY_EN
    send_bit((^c) ^ pbad);
`endif
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic run_char(input string nm, input logic [7:0] c,
                          input bit stop, input bit pbad, input int ep,
                          input int ee, input logic [7:0] eb);
    int p0;
    int e0;
    p0 = np;
    e0 = ne;
    send_frame(c, stop, pbad);
    chk({nm, "_pronto"}, np - p0, ep);
    chk({nm, "_erro"}, ne - e0, ee);
    chk({nm, "_bcd"}, int'(bcd), int'(eb));
    chk({nm, "_state"}, int'(db_estado), 0);
  endtask

  task automatic model(input logic [7:0] c, input bit stop, input bit pbad,
                       output int ep, output int ee);
    bit ok;
    int d;
    ok = stop && (c >= 8'h30) && (c <= 8'h39);
`ifdef RX_PARITY_EN
    if (pbad) ok = 1'b0;
`endif
    d = int'(c) - 48;
    ep = 0;
    ee = 0;
    if (!ok) begin
      ee = 1;
      held = -1;
    end else if (held < 0) begin
      held = d;
    end else begin
      mbcd = 8'(held * 16 + d);
      held = -1;
      ep = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    held = -1;
    mbcd = 8'h00;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    int p0;
    int e0;
    int ep;
    int ee;
    logic [7:0] c;
    bit st;
    bit pb;
    int r;

    tbl[0]  = '{8'h33, 1'b1, 0, 0, 8'h00};
    tbl[1]  = '{8'h32, 1'b1, 1, 0, 8'h32};
    tbl[2]  = '{8'h39, 1'b1, 0, 0, 8'h32};
    tbl[3]  = '{8'h30, 1'b1, 1, 0, 8'h90};
    tbl[4]  = '{8'h30, 1'b1, 0, 0, 8'h90};
    tbl[5]  = '{8'h37, 1'b1, 1, 0, 8'h07};
    tbl[6]  = '{8'h35, 1'b1, 0, 0, 8'h07};
    tbl[7]  = '{8'h41, 1'b1, 0, 1, 8'h07};
    tbl[8]  = '{8'h31, 1'b1, 0, 0, 8'h07};
    tbl[9]  = '{8'h38, 1'b1, 1, 0, 8'h18};
    tbl[10] = '{8'h34, 1'b0, 0, 1, 8'h18};
    tbl[11] = '{8'h36, 1'b1, 0, 0, 8'h18};
    tbl[12] = '{8'h31, 1'b1, 1, 0, 8'h61};
    tbl[13] = '{8'h39, 1'b1, 0, 0, 8'h61};
    tbl[14] = '{8'h3A, 1'b1, 0, 1, 8'h61};
    tbl[15] = '{8'h38, 1'b1, 0, 0, 8'h61};
    tbl[16] = '{8'h2F, 1'b1, 0, 1, 8'h61};
    tbl[17] = '{8'h30, 1'b1, 0, 0, 8'h61};
    tbl[18] = '{8'h39, 1'b1, 1, 0, 8'h09};

    do_reset();
    chk("reset_bcd", int'(bcd), 0);
    chk("reset_pronto", int'(pronto), 0);
    chk("reset_erro", int'(erro), 0);
    chk("reset_state", int'(db_estado), 0);

    for (int i = 0; i < 19; i++)
      run_char($sformatf("tbl%0d", i), tbl[i].ch, tbl[i].stop, 1'b0,
               tbl[i].exp_p, tbl[i].exp_e, tbl[i].exp_bcd);

    // Short glitch on an idle line.
    p0 = np;
    e0 = ne;
    rx_serial = 1'b0;
    repeat (CPB / 4) @(posedge clock);
    #1;
    rx_serial = 1'b1;
    repeat (2 * CPB) @(posedge clock);
    #1;
    chk("glitch_pronto", np - p0, 0);
    chk("glitch_erro", ne - e0, 0);
    chk("glitch_state", int'(db_estado), 0);

    // Reset during data bit 3 of the units character.
    do_reset();
    run_char("abort_tens", 8'h32, 1'b1, 1'b0, 0, 0, 8'h00);
    p0 = np;
    e0 = ne;
    send_bit(1'b0);
    c = 8'h35;
    for (int i = 0; i < 3; i++) send_bit(c[i]);
    rx_serial = c[3];
    repeat (CPB / 2) @(posedge clock);
    #1;
    chk("abort_in_data", int'(db_estado), 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rx_serial = 1'b1;
    repeat (3 * CPB) @(posedge clock);
    #1;
    chk("abort_pronto", np - p0, 0);
    chk("abort_erro", ne - e0, 0);
    chk("abort_state", int'(db_estado), 0);
    run_char("abort_u1", 8'h32, 1'b1, 1'b0, 0, 0, 8'h00);
    run_char("abort_u2", 8'h35, 1'b1, 1'b0, 1, 0, 8'h25);

    // Held-low break line: one framing error, then idle.
    p0 = np;
    e0 = ne;
    rx_serial = 1'b0;
    repeat (12 * CPB) @(posedge clock);
    #1;
    chk("break_erro", ne - e0, 1);
    chk("break_pronto", np - p0, 0);
    chk("break_state", int'(db_estado), 0);
    rx_serial = 1'b1;
    repeat (2 * CPB) @(posedge clock);
    #1;
    run_char("brk_t", 8'h33, 1'b1, 1'b0, 0, 0, 8'h25);
    run_char("brk_u", 8'h34, 1'b1, 1'b0, 1, 0, 8'h34);

`ifdef RX_PARITY_EN
    run_char("par_ok", 8'h37, 1'b1, 1'b0, 0, 0, 8'h34);
    run_char("par_bad", 8'h33, 1'b1, 1'b1, 0, 1, 8'h34);
`endif

    // Random characters against the pairing model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      st = 1'b1;
      pb = 1'b0;
      c = 8'(8'h30 + $urandom_range(0, 9));
      if (r == 7) c = 8'($urandom_range(0, 255));
      if (r == 8) st = 1'b0;
`ifdef RX_PARITY_EN
      if (r == 9) pb = 1'b1;
`endif
      model(c, st, pb, ep, ee);
      run_char($sformatf("rnd%0d", i), c, st, pb, ep, ee, mbcd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
